// File: rtl/instr_split_reg_pkg.sv
// Shared types and constants for the instruction register and field splitter.
package instr_split_reg_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_HI_W = 4;
   localparam int unsigned OPC_W   = 6;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned OFF_W   = 26;

   // Field bit positions inside the instruction word
   localparam int unsigned OPC_HI   = 31;
   localparam int unsigned RS_LO    = 21;
   localparam int unsigned RT_LO    = 16;
   localparam int unsigned RD_LO    = 11;
   localparam int unsigned SHAMT_LO = 6;

   // All-zero word decodes as sll $0,$0,0, i.e. the MIPS NOP
   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      HOLD = 2'b10
   } isr_state_e;

endpackage

// File: rtl/instr_field_split.sv
// Combinational splitter: IR and captured PC nibble to decoded fields.
module instr_field_split
   import instr_split_reg_pkg::*;
(
   input  logic [INSTR_W-1:0] ir,
   input  logic [PC_HI_W-1:0] pc_hi,
   output logic [OPC_W-1:0]   opcode,
   output logic [REG_W-1:0]   rs,
   output logic [REG_W-1:0]   rt,
   output logic [REG_W-1:0]   rd,
   output logic [REG_W-1:0]   shamt,
   output logic [FUNCT_W-1:0] funct,
   output logic [IMM_W-1:0]   imm16,
   output logic [31:0]        imm_sext,
   output logic [OFF_W-1:0]   offset26,
   output logic [31:0]        jump_target
);

   // Plain field slicing; immediate sign-extended, jump target rebuilt
   always_comb begin
      opcode      = ir[OPC_HI -: OPC_W];
      rs          = ir[RS_LO +: REG_W];
      rt          = ir[RT_LO +: REG_W];
      rd          = ir[RD_LO +: REG_W];
      shamt       = ir[SHAMT_LO +: REG_W];
      funct       = ir[FUNCT_W-1:0];
      imm16       = ir[IMM_W-1:0];
      imm_sext    = {{(32-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
      offset26    = ir[OFF_W-1:0];
      jump_target = {pc_hi, ir[OFF_W-1:0], 2'b00};
   end

endmodule

// File: rtl/instr_split_reg.sv
// Instruction register: fetch handshake with timeout, IR latch, field split.
module instr_split_reg
   import instr_split_reg_pkg::*;
#(
   parameter int unsigned          MEM_TIMEOUT = 16,
   parameter logic [INSTR_W-1:0]   RESET_IR    = NOP
)(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               fetch_req,
   input  logic               ir_clear,
   input  logic [31:0]        pc_in,
   output logic               mem_rd,
   input  logic               mem_valid,
   input  logic [INSTR_W-1:0] mem_data,
   output logic               busy,
   output logic               instr_valid,
   output logic               fetch_err,
   output logic [OPC_W-1:0]   opcode,
   output logic [REG_W-1:0]   rs,
   output logic [REG_W-1:0]   rt,
   output logic [REG_W-1:0]   rd,
   output logic [REG_W-1:0]   shamt,
   output logic [FUNCT_W-1:0] funct,
   output logic [IMM_W-1:0]   imm16,
   output logic [31:0]        imm_sext,
   output logic [OFF_W-1:0]   offset26,
   output logic [31:0]        jump_target
);

   localparam int unsigned   CNT_W    = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam bit            TO_EN    = (MEM_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(MEM_TIMEOUT - 1) : '0;

   isr_state_e          state, state_nxt;
   logic [INSTR_W-1:0]  ir;
   logic [PC_HI_W-1:0]  pc_hi;
   logic [CNT_W-1:0]    cnt;

   logic                ir_load;
   logic                ir_rst;
   logic                pc_load;
   logic                cnt_clr;
   logic                cnt_inc;
   logic                err_set;
   logic                pc_lo_unused;

   // Only the PC region nibble is needed for jump target reconstruction
   assign pc_lo_unused = ^pc_in[31-PC_HI_W:0];

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state and datapath controls; ir_clear overrides everything
   always_comb begin
      state_nxt = state;
      ir_load   = 1'b0;
      ir_rst    = 1'b0;
      pc_load   = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      err_set   = 1'b0;
      if (ir_clear) begin
         state_nxt = IDLE;
         ir_rst    = 1'b1;
         cnt_clr   = 1'b1;
      end else begin
         case (state)
            IDLE, HOLD: begin
               if (fetch_req) begin
                  pc_load   = 1'b1;
                  cnt_clr   = 1'b1;
                  state_nxt = WAIT;
               end
            end
            WAIT: begin
               if (mem_valid) begin
                  ir_load   = 1'b1;
                  state_nxt = HOLD;
               end else if (TO_EN && (cnt == CNT_LAST)) begin
                  err_set   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  cnt_inc   = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // IR, PC nibble, timeout counter and error pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ir        <= RESET_IR;
         pc_hi     <= '0;
         cnt       <= '0;
         fetch_err <= 1'b0;
      end else begin
         fetch_err <= err_set;
         if (ir_rst)       ir <= RESET_IR;
         else if (ir_load) ir <= mem_data;
         if (pc_load) pc_hi <= pc_in[31 -: PC_HI_W];
         if (cnt_clr)                    cnt <= '0;
         else if (cnt_inc && (cnt != '1)) cnt <= cnt + CNT_W'(1);
      end
   end

   // Handshake flags are straight decodes of the state register
   assign mem_rd      = (state == WAIT);
   assign busy        = (state == WAIT);
   assign instr_valid = (state == HOLD);

   instr_field_split u_split (
      .ir          (ir),
      .pc_hi       (pc_hi),
      .opcode      (opcode),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .shamt       (shamt),
      .funct       (funct),
      .imm16       (imm16),
      .imm_sext    (imm_sext),
      .offset26    (offset26),
      .jump_target (jump_target)
   );

endmodule

// File: tb/tb_instr_split_reg.sv
// Directed bench for instr_split_reg with a short fetch timeout.
module tb_instr_split_reg;

   logic        clk;
   logic        reset_n;
   logic        fetch_req;
   logic        ir_clear;
   logic [31:0] pc_in;
   logic        mem_rd;
   logic        mem_valid;
   logic [31:0] mem_data;
   logic        busy;
   logic        instr_valid;
   logic        fetch_err;
   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic [31:0] imm_sext;
   logic [25:0] offset26;
   logic [31:0] jump_target;

   int n_chk  = 0;
   int n_pass = 0;

   // Disassembly monitor on the word the bench expects to have been fetched
   logic [31:0] mon_ir;
   logic [3:0]  mon_pc_hi;
   logic [5:0]  m_opc, m_funct;
   logic [4:0]  m_rs, m_rt, m_rd, m_sh;
   logic [15:0] m_imm;
   logic [31:0] m_sext, m_jt;
   logic [25:0] m_off;

   instr_split_reg #(.MEM_TIMEOUT(4), .RESET_IR(32'h0000_0000)) dut (
      .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .ir_clear(ir_clear),
      .pc_in(pc_in), .mem_rd(mem_rd), .mem_valid(mem_valid), .mem_data(mem_data),
      .busy(busy), .instr_valid(instr_valid), .fetch_err(fetch_err),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .imm16(imm16), .imm_sext(imm_sext), .offset26(offset26), .jump_target(jump_target)
   );

   instr_field_split u_mon (
      .ir(mon_ir), .pc_hi(mon_pc_hi), .opcode(m_opc), .rs(m_rs), .rt(m_rt),
      .rd(m_rd), .shamt(m_sh), .funct(m_funct), .imm16(m_imm), .imm_sext(m_sext),
      .offset26(m_off), .jump_target(m_jt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
      else             n_pass++;
   endtask

   // Advance one rising edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic disasm();
      $display("disasm ir=%h opc=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h imm=%h sext=%h off=%h jt=%h",
               mon_ir, m_opc, m_rs, m_rt, m_rd, m_sh, m_funct, m_imm, m_sext, m_off, m_jt);
   endtask

   initial begin
      int cycles;
      reset_n   = 1'b0;
      fetch_req = 1'b0;
      ir_clear  = 1'b0;
      pc_in     = 32'h0;
      mem_valid = 1'b0;
      mem_data  = 32'h0;
      mon_ir    = 32'h0;
      mon_pc_hi = 4'h0;
      repeat (2) step();

      check("rst_mem_rd",      32'(mem_rd),      32'h0);
      check("rst_busy",        32'(busy),        32'h0);
      check("rst_instr_valid", 32'(instr_valid), 32'h0);
      check("rst_fetch_err",   32'(fetch_err),   32'h0);
      check("rst_opcode",      32'(opcode),      32'h0);
      check("rst_jump_target", jump_target,      32'h0);
      reset_n = 1'b1;
      step();
      check("idle_mem_rd", 32'(mem_rd), 32'h0);

      // Jump instruction with PC region 0xA
      pc_in     = 32'hA000_0040;
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      check("j_mem_rd", 32'(mem_rd), 32'h1);
      check("j_busy",   32'(busy),   32'h1);
      pc_in     = 32'h5000_0000;
      fetch_req = 1'b1;               // must be ignored while waiting
      step();
      fetch_req = 1'b0;
      step();
      mem_valid = 1'b1;
      mem_data  = 32'h0800_0010;
      step();
      mem_valid = 1'b0;
      mon_ir = 32'h0800_0010; mon_pc_hi = 4'hA; disasm();
      check("j_instr_valid", 32'(instr_valid), 32'h1);
      check("j_mem_rd_off",  32'(mem_rd),      32'h0);
      check("j_opcode",      32'(opcode),      32'h02);
      check("j_offset26",    32'(offset26),    32'h10);
      check("j_jump_target", jump_target,      32'hA000_0040);

      // Response outside WAIT is ignored
      mem_valid = 1'b1;
      mem_data  = 32'hFFFF_FFFF;
      step();
      mem_valid = 1'b0;
      check("stray_opcode", 32'(opcode),      32'h02);
      check("stray_valid",  32'(instr_valid), 32'h1);

      // Refetch from HOLD: valid drops, old fields held, PC nibble recaptured
      pc_in     = 32'h3000_0000;
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      check("refetch_valid",  32'(instr_valid), 32'h0);
      check("refetch_mem_rd", 32'(mem_rd),      32'h1);
      check("refetch_opcode", 32'(opcode),      32'h02);
      check("refetch_off26",  32'(offset26),    32'h10);
      check("refetch_jt",     jump_target,      32'h3000_0040);
      step();
      mem_valid = 1'b1;
      mem_data  = 32'h8C49_FFFC;
      step();
      mem_valid = 1'b0;
      mon_ir = 32'h8C49_FFFC; mon_pc_hi = 4'h3; disasm();
      check("lw_valid",    32'(instr_valid), 32'h1);
      check("lw_opcode",   32'(opcode),      32'h23);
      check("lw_rs",       32'(rs),          32'd2);
      check("lw_rt",       32'(rt),          32'd9);
      check("lw_rd",       32'(rd),          32'd31);
      check("lw_shamt",    32'(shamt),       32'd31);
      check("lw_funct",    32'(funct),       32'h3C);
      check("lw_imm16",    32'(imm16),       32'hFFFC);
      check("lw_imm_sext", imm_sext,         32'hFFFF_FFFC);

      // Timeout: no response, read held exactly MEM_TIMEOUT cycles
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      cycles = 0;
      while (mem_rd && cycles < 10) begin
         cycles++;
         step();
      end
      check("to_rd_cycles", 32'(cycles),      32'd4);
      check("to_fetch_err", 32'(fetch_err),   32'h1);
      check("to_busy",      32'(busy),        32'h0);
      check("to_valid",     32'(instr_valid), 32'h0);
      check("to_ir_kept",   32'(opcode),      32'h23);
      step();
      check("to_err_pulse", 32'(fetch_err),   32'h0);
      check("to_idle_rd",   32'(mem_rd),      32'h0);

      // ir_clear beats a same-cycle response
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      check("clr_mem_rd", 32'(mem_rd), 32'h1);
      step();
      mem_valid = 1'b1;
      mem_data  = 32'h0000_0020;
      ir_clear  = 1'b1;
      step();
      mem_valid = 1'b0;
      ir_clear  = 1'b0;
      check("clr_valid",  32'(instr_valid), 32'h0);
      check("clr_busy",   32'(busy),        32'h0);
      check("clr_err",    32'(fetch_err),   32'h0);
      check("clr_funct",  32'(funct),       32'h0);
      check("clr_opcode", 32'(opcode),      32'h0);
      check("clr_sext",   imm_sext,         32'h0);
      step();
      check("clr_idle_rd", 32'(mem_rd), 32'h0);
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      check("clr_accept", 32'(mem_rd), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
